// File: rtl/sched_mac_filtros_pkg.sv
// Shared types and constants for the time-multiplexed IIR MAC sequencer.
package sched_mac_pkg;

  localparam int unsigned SEL_W      = 4;
  localparam int unsigned N_TAPS_DEF = 5;

  // Channel names for the default three-filter arrangement
  localparam int unsigned CH_PB = 0;  // paso-bajo
  localparam int unsigned CH_BP = 1;  // paso-banda
  localparam int unsigned CH_PA = 2;  // paso-alto 20 Hz

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MAC,
    STORE,
    SHIFT
  } state_t;

endpackage

// File: rtl/sched_mac_filtros_rr_arbiter.sv
// Grant selection for the shared MAC: round-robin from rr+1 with wrap.
// With SCHED_FIXED_PRIO_EN defined, the lowest pending index always wins and
// the rr input is removed.
module rr_arbiter
  import sched_mac_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned CH_W = 2
) (
`ifndef SCHED_FIXED_PRIO_EN
  input  logic [CH_W-1:0] rr,
`endif
  input  logic [N_CH-1:0] pend,
  output logic [N_CH-1:0] gnt,
  output logic [CH_W-1:0] idx
);

  // Scan candidates in priority order; the first pending one is granted
  always_comb begin
    logic             found;
    logic [CH_W-1:0]  ci;
    int unsigned      c;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    ci    = '0;
    c     = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
`ifdef SCHED_FIXED_PRIO_EN
      c = i;
`else
      c = (32'(rr) + i + 1) % N_CH;
`endif
      ci = CH_W'(c);
      if (!found && pend[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/sched_mac_filtros.sv
// Sequencer sharing one MAC datapath among N_CH second-order IIR channels.
// Latches sample requests, arbitrates (round-robin, or fixed priority when
// SCHED_FIXED_PRIO_EN is defined) and drives tap select, accumulator clear,
// history write/shift and output-register load. All outputs are registered.
module sched_mac_filtros
  import sched_mac_pkg::*;
#(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned N_TAPS = N_TAPS_DEF,
  parameter int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  output logic             busy,
  output logic [CH_W-1:0]  ch_sel,
  output logic [SEL_W-1:0] sel,
  output logic             rst_acum,
  output logic             leer,
  output logic             desp,
  output logic [N_CH-1:0]  leer_y,
  output logic [N_CH-1:0]  overrun
);

  state_t           state, state_n;
  logic [N_CH-1:0]  pend;
  logic [N_CH-1:0]  gnt, gnt_clr;
  logic [CH_W-1:0]  gnt_idx;
  logic [CH_W-1:0]  ch_sel_n;
  logic [SEL_W-1:0] sel_n;
  logic             busy_n, rst_acum_n, leer_n, desp_n;
  logic [N_CH-1:0]  leer_y_n;

`ifndef SCHED_FIXED_PRIO_EN
  logic [CH_W-1:0]  rr, rr_n;
`endif

  rr_arbiter #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_arb (
`ifndef SCHED_FIXED_PRIO_EN
    .rr   (rr),
`endif
    .pend (pend),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // Next state, grant and the next value of every registered output.
  // Outputs are decoded from the next state so they align with the state.
  always_comb begin
    state_n  = state;
    gnt_clr  = '0;
    ch_sel_n = ch_sel;
    sel_n    = '0;
`ifndef SCHED_FIXED_PRIO_EN
    rr_n     = rr;
`endif
    unique case (state)
      IDLE: begin
        if (|pend) begin
          gnt_clr  = gnt;
          ch_sel_n = gnt_idx;
`ifndef SCHED_FIXED_PRIO_EN
          rr_n     = gnt_idx;
`endif
          state_n  = CLR;
        end
      end
      CLR: begin
        state_n = MAC;
      end
      MAC: begin
        if (sel == SEL_W'(N_TAPS - 1)) begin
          state_n = STORE;
        end else begin
          sel_n = sel + SEL_W'(1);
        end
      end
      STORE: begin
        state_n = SHIFT;
      end
      SHIFT: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n     = (state_n != IDLE);
    rst_acum_n = (state_n == CLR);
    leer_n     = (state_n == STORE);
    desp_n     = (state_n == SHIFT);
    leer_y_n   = (state_n == STORE) ? (N_CH'(1) << ch_sel_n) : '0;
  end

  // State, pending/overrun bookkeeping and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= '0;
      overrun  <= '0;
      busy     <= 1'b0;
      ch_sel   <= '0;
      sel      <= '0;
      rst_acum <= 1'b0;
      leer     <= 1'b0;
      desp     <= 1'b0;
      leer_y   <= '0;
`ifndef SCHED_FIXED_PRIO_EN
      rr       <= CH_W'(N_CH - 1);
`endif
    end else begin
      state    <= state_n;
      // A request coinciding with its own grant stays pending (set wins)
      pend     <= (pend & ~gnt_clr) | req;
      overrun  <= overrun | (req & pend & ~gnt_clr);
      busy     <= busy_n;
      ch_sel   <= ch_sel_n;
      sel      <= sel_n;
      rst_acum <= rst_acum_n;
      leer     <= leer_n;
      desp     <= desp_n;
      leer_y   <= leer_y_n;
`ifndef SCHED_FIXED_PRIO_EN
      rr       <= rr_n;
`endif
    end
  end

endmodule
